fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch responder to the CPU control FSM. Consumes do_fetch/do_next/do_reset/do_halt
//  strobes, owns the program counter, and runs a req/ack read of instruction memory with variable
//  latency. Presents the latched instruction and its opcode to decode/regfile until do_next advances the PC.
// PARAMETERS
//  ADDR_WIDTH   8    PC / instruction-memory address width
//  INSTR_WIDTH  16   instruction word width
//  OPCODE_SIZE  4    opcode field width, taken from instruction MSBs
//  RESET_PC     0    PC value after reset / do_reset
//  TIMEOUT      15   max cycles waiting for imem_ack before fault (1..255)
// PORTS
//  clock          in   1            system clock, rising edge
//  reset          in   1            asynchronous, active-high reset
//  do_fetch       in   1            control: start fetch at pc
//  do_next        in   1            control: advance pc, release instruction
//  do_reset       in   1            control: synchronous return to RESET_PC
//  do_halt        in   1            control: stop fetching
//  branch_taken   in   1            sampled with do_next: take branch
//  branch_offset  in   ADDR_WIDTH   two's-complement pc offset for taken branch
//  imem_req       out  1            read request to instruction memory
//  imem_addr      out  ADDR_WIDTH   read address (== pc while imem_req)
//  imem_ack       in   1            memory: imem_rdata valid this cycle
//  imem_rdata     in   INSTR_WIDTH  memory read data
//  instr          out  INSTR_WIDTH  latched instruction
//  opcode         out  OPCODE_SIZE  instr[INSTR_WIDTH-1 -: OPCODE_SIZE]
//  pc             out  ADDR_WIDTH   current program counter
//  fetch_valid    out  1            instr holds a fetched word for current pc
//  busy           out  1            fetch in flight (state REQ)
//  fault          out  1            fetch timed out; sticky until reset/do_reset
// BEHAVIOUR
//  - States: IDLE, REQ, HOLD, HALTED. All outputs registered.
//  - Reset (async): state=IDLE, pc=RESET_PC, instr=0, imem_req=0, fetch_valid=0, busy=0, fault=0, timer=0.
//  - Priority per edge: do_reset > do_halt > state action. do_reset acts as reset from any state.
//  - IDLE: do_fetch -> REQ next edge; imem_req=1, imem_addr=pc, timer cleared. Else hold.
//  - REQ: imem_req held high, addr stable, until imem_ack. On ack: instr<=imem_rdata, imem_req<=0,
//    fetch_valid<=1, -> HOLD (fetch_valid high 1 cycle after ack). Min latency do_fetch->fetch_valid = 2 cycles
//    with ack in first REQ cycle. timer increments each REQ cycle without ack; at TIMEOUT cycles -> fault<=1,
//    imem_req<=0, -> HALTED.
//  - HOLD: instr/opcode stable. do_next: pc <= branch_taken ? pc+branch_offset : pc+1, modulo 2^ADDR_WIDTH
//    (wraps, no fault); fetch_valid<=0; -> IDLE. do_next and do_fetch together: do_next wins, fetch dropped.
//  - do_fetch outside IDLE ignored; do_next outside HOLD ignored (pc unchanged); imem_ack outside REQ ignored.
//  - do_halt: from any state -> HALTED; REQ aborted (imem_req<=0 next edge, late ack ignored);
//    instr/pc retained, fetch_valid retained. HALTED exits only via reset/do_reset.
//  - Reset/do_reset mid-REQ: imem_req deasserted, pending ack ignored, pc=RESET_PC.
// TESTING
//  1. Reset, do_fetch, memory acks 3 cycles later with 16'hA123 -> imem_addr=0 during REQ, instr=16'hA123,
//     opcode=4'hA, fetch_valid high, busy low.
//  2. HOLD at pc=5, do_next branch_taken=0 -> pc=6; then pc=6 do_next branch_taken=1 offset=8'hFC -> pc=2.
//  3. pc=8'hFF, do_next not taken -> pc=8'h00, fault=0.
//  4. do_fetch, never ack -> after 15 REQ cycles fault=1, imem_req=0, HALTED; do_fetch ignored; do_reset
//     -> IDLE, fault=0, pc=0.
//  5. do_halt during REQ then ack next cycle -> imem_req low, instr unchanged, state HALTED.
//  6. Async reset asserted mid-REQ between clock edges -> imem_req/busy low immediately, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch responder for the CPU control FSM. It owns the program
// counter and reads instruction memory over a req/ack handshake whose
// latency is variable. The fetched word is held for decode/regfile until
// do_next advances the PC, either sequentially or by a branch offset.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_i            asynchronous active-high reset
//   do_fetch_i       start a fetch at pc (only honoured in IDLE)
//   do_next_i        advance pc and release instruction (only in HOLD)
//   do_reset_i       synchronous return to RESET_PC from any state
//   do_halt_i        stop fetching; only reset/do_reset leaves HALTED
//   branch_taken_i   sampled with do_next: add branch_offset instead of 1
//   branch_offset_i  two's-complement pc offset
//   imem_req_o       read request to instruction memory
//   imem_addr_o      read address (equals pc)
//   imem_ack_i       imem_rdata_i valid this cycle
//   imem_rdata_i     memory read data
//   instr_o          latched instruction
//   opcode_o         instruction MSBs
//   pc_o             current program counter
//   fetch_valid_o    instr_o holds the word fetched for the current pc
//   busy_o           fetch in flight
//   fault_o          fetch timed out; sticky until reset/do_reset
module fetch_unit #(
    parameter int                  ADDR_WIDTH  = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter int                  OPCODE_SIZE = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  TIMEOUT     = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   do_fetch_i,
    input  logic                   do_next_i,
    input  logic                   do_reset_i,
    input  logic                   do_halt_i,
    input  logic                   branch_taken_i,
    input  logic [ADDR_WIDTH-1:0]  branch_offset_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [OPCODE_SIZE-1:0] opcode_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   fetch_valid_o,
    output logic                   busy_o,
    output logic                   fault_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    // Timer value on the last allowed un-acked REQ cycle.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic                     req_q, req_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     fault_q, fault_d;
    logic [7:0]               timer_q, timer_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        fault_d = fault_q;
        timer_d = timer_q;

        if (do_reset_i) begin
            state_d = IDLE;
            pc_d    = RESET_PC;
            instr_d = '0;
            req_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            fault_d = 1'b0;
            timer_d = '0;
        end else if (do_halt_i) begin
            // Abort any request; instruction, pc and valid flag are kept.
            state_d = HALTED;
            req_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (do_fetch_i) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        busy_d  = 1'b1;
                        timer_d = '0;
                    end
                end
                REQ: begin
                    if (imem_ack_i) begin
                        state_d = HOLD;
                        instr_d = imem_rdata_i;
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                    end else if (timer_q == TIMER_LAST) begin
                        state_d = HALTED;
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        fault_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                HOLD: begin
                    // do_next takes precedence; a simultaneous do_fetch is dropped
                    // because fetches only start from IDLE.
                    if (do_next_i) begin
                        pc_d    = branch_taken_i ? pc_q + branch_offset_i
                                                 : pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                HALTED: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[INSTR_WIDTH-1 -: OPCODE_SIZE];
    assign pc_o          = pc_q;
    assign fetch_valid_o = valid_q;
    assign busy_o        = busy_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        do_fetch_i, do_next_i, do_reset_i, do_halt_i;
    logic        branch_taken_i;
    logic [7:0]  branch_offset_i;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_rdata_i;
    logic [15:0] instr_o;
    logic [3:0]  opcode_o;
    logic [7:0]  pc_o;
    logic        fetch_valid_o, busy_o, fault_o;

    fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .do_fetch_i(do_fetch_i), .do_next_i(do_next_i),
        .do_reset_i(do_reset_i), .do_halt_i(do_halt_i),
        .branch_taken_i(branch_taken_i), .branch_offset_i(branch_offset_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o), .opcode_o(opcode_o), .pc_o(pc_o),
        .fetch_valid_o(fetch_valid_o), .busy_o(busy_o), .fault_o(fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] data;
        int          lat;       // un-acked REQ cycles before ack
        logic        taken;
        logic [7:0]  offset;
        logic        also_fetch; // assert do_fetch together with do_next
        logic [7:0]  exp_pc;    // pc after do_next
    } vec_t;

    vec_t        vecs[7];
    logic [15:0] sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  pc_model;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One complete fetch/next transaction from IDLE.
    task automatic run_vec(input vec_t v);
        logic [15:0] exp_w;
        do_fetch_i = 1'b1;
        tick();
        do_fetch_i = 1'b0;
        check("req_high", imem_req_o, 1);
        check("busy_high", busy_o, 1);
        check("req_addr", imem_addr_o, pc_model);
        for (int i = 0; i < v.lat; i++) tick();
        check("req_held", imem_req_o, 1);
        imem_ack_i   = 1'b1;
        imem_rdata_i = v.data;
        sb_q.push_back(v.data);
        tick();
        imem_ack_i   = 1'b0;
        imem_rdata_i = 16'h0;
        check("fetch_valid", fetch_valid_o, 1);
        check("req_low_after_ack", imem_req_o, 0);
        check("busy_low", busy_o, 0);
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            exp_w = sb_q.pop_front();
            check("instr", instr_o, exp_w);
            check("opcode", opcode_o, exp_w[15:12]);
        end
        do_next_i       = 1'b1;
        do_fetch_i      = v.also_fetch;
        branch_taken_i  = v.taken;
        branch_offset_i = v.offset;
        tick();
        do_next_i  = 1'b0;
        do_fetch_i = 1'b0;
        branch_taken_i = 1'b0;
        check("pc_next", pc_o, v.exp_pc);
        check("valid_cleared", fetch_valid_o, 0);
        check("req_after_next", imem_req_o, 0);
        check("no_fault", fault_o, 0);
        pc_model = v.exp_pc;
        $display("txn data=%h lat=%0d taken=%0d off=%h pc=%h", v.data, v.lat, v.taken, v.offset, pc_o);
    endtask

    initial begin
        int n;
        vecs[0] = '{16'hA123, 3, 1'b0, 8'h00, 1'b0, 8'h01};
        vecs[1] = '{16'h5BCD, 0, 1'b1, 8'h04, 1'b0, 8'h05};
        vecs[2] = '{16'h1111, 1, 1'b0, 8'h00, 1'b1, 8'h06};
        vecs[3] = '{16'h2222, 2, 1'b1, 8'hFC, 1'b0, 8'h02};
        vecs[4] = '{16'hF00F, 0, 1'b1, 8'hFD, 1'b0, 8'hFF};
        vecs[5] = '{16'h0E0E, 1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[6] = '{16'h3333, 0, 1'b0, 8'h00, 1'b0, 8'h01};

        rst_i = 1'b1;
        do_fetch_i = 0; do_next_i = 0; do_reset_i = 0; do_halt_i = 0;
        branch_taken_i = 0; branch_offset_i = 0; imem_ack_i = 0; imem_rdata_i = 0;
        pc_model = 8'h00;
        tick(); tick();
        check("rst_pc", pc_o, 0);
        check("rst_req", imem_req_o, 0);
        check("rst_valid", fetch_valid_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_fault", fault_o, 0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // do_next and imem_ack outside their states are ignored
        do_next_i = 1'b1; branch_taken_i = 1'b1; branch_offset_i = 8'h10;
        imem_ack_i = 1'b1; imem_rdata_i = 16'hDEAD;
        tick();
        do_next_i = 1'b0; branch_taken_i = 1'b0; imem_ack_i = 1'b0;
        check("idle_next_pc", pc_o, 8'h00);
        check("idle_ack_instr", instr_o, 16'h0E0E);
        $display("txn idle do_next/ack ignored pc=%h", pc_o);

        run_vec(vecs[6]);

        // Timeout: never ack
        do_fetch_i = 1'b1;
        tick();
        do_fetch_i = 1'b0;
        check("to_addr", imem_addr_o, 8'h01);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (fault_o) begin n = i; break; end
        end
        check("timeout_cycles", n, 15);
        check("timeout_req", imem_req_o, 0);
        check("timeout_busy", busy_o, 0);
        do_fetch_i = 1'b1;
        tick();
        do_fetch_i = 1'b0;
        check("halted_fetch_ignored", imem_req_o, 0);
        check("fault_sticky", fault_o, 1);
        do_reset_i = 1'b1;
        tick();
        do_reset_i = 1'b0;
        check("dorst_fault", fault_o, 0);
        check("dorst_pc", pc_o, 8'h00);
        check("dorst_instr", instr_o, 0);
        do_fetch_i = 1'b1;
        tick();
        do_fetch_i = 1'b0;
        check("dorst_idle_fetch", imem_req_o, 1);
        $display("txn timeout after %0d cycles, do_reset", n);

        // do_halt during REQ, late ack
        tick();
        do_halt_i = 1'b1;
        tick();
        do_halt_i = 1'b0;
        check("halt_req", imem_req_o, 0);
        check("halt_busy", busy_o, 0);
        imem_ack_i = 1'b1; imem_rdata_i = 16'hBEEF;
        tick();
        imem_ack_i = 1'b0;
        check("halt_instr", instr_o, 16'h0000);
        check("halt_valid", fetch_valid_o, 0);
        do_fetch_i = 1'b1;
        tick();
        do_fetch_i = 1'b0;
        check("halt_stays", imem_req_o, 0);
        $display("txn halt during REQ, late ack ignored");

        // Async reset mid-REQ
        do_reset_i = 1'b1;
        tick();
        do_reset_i = 1'b0;
        pc_model = 8'h00;
        run_vec(vecs[6]);
        do_fetch_i = 1'b1;
        tick();
        do_fetch_i = 1'b0;
        check("pre_arst_req", imem_req_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_req", imem_req_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_pc", pc_o, 8'h00);
        tick();
        rst_i = 1'b0;
        imem_ack_i = 1'b1; imem_rdata_i = 16'h7777;
        tick();
        imem_ack_i = 1'b0;
        check("arst_ack_ignored", fetch_valid_o, 0);
        $display("txn async reset mid-REQ");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
